// File: rtl/uart_byte_rx_if.sv
// Byte-stream handshake between the serial receiver and its downstream consumer.
// The receiver owns the byte side; the consumer (or a line driver) supplies rxd.
`timescale 1ns/1ps
interface uart_byte_rx_if;
    logic       rxd;
    logic [7:0] data;
    logic       write;
    logic       frame_err;
    logic       busy;
    logic [9:0] byte_cnt;

    modport master (
        input  rxd,
        output data,
        output write,
        output frame_err,
        output busy,
        output byte_cnt
    );

    modport slave (
        output rxd,
        input  data,
        input  write,
        input  frame_err,
        input  busy,
        input  byte_cnt
    );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 serial byte receiver: mid-bit sampling from a free-running bit-period counter,
// one-cycle write/frame_err strobes and a wrapping 10-bit delivered-byte count.
`timescale 1ns/1ps
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic           clk,
    input  logic           nrst,
    uart_byte_rx_if.master bus
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             sync1;
    logic             rxd_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;
    logic             write_nxt;
    logic             ferr_nxt;
    logic             sample;

    // Synchroniser idles high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= bus.rxd;
            rxd_s <= sync1;
        end
    end

    always_comb begin
        sample = 1'b0;
        case (state)
            START:      sample = (cnt == HALF_LAST);
            DATA, STOP: sample = (cnt == BIT_LAST);
            default:    sample = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        write_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) state_nxt = START;
            end
            START: begin
                if (sample) begin
                    if (!rxd_s) begin
                        state_nxt = DATA;
                        idx_nxt   = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shreg_nxt[idx] = rxd_s;
                    idx_nxt        = idx + 3'd1;
                    if (idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    if (rxd_s) begin
                        write_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            // A held-low line must return high before another start is honoured.
            WAIT_HIGH: begin
                if (rxd_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The period counter restarts on every state change so each phase times from its own entry.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
            shreg <= 8'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
            if (state_nxt != state) cnt <= '0;
            else                    cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.data      <= 8'd0;
            bus.write     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.byte_cnt  <= 10'd0;
        end else begin
            bus.write     <= write_nxt;
            bus.frame_err <= ferr_nxt;
            if (write_nxt) begin
                bus.data     <= shreg_nxt;
                bus.byte_cnt <= bus.byte_cnt + 10'd1;
            end
        end
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomised frame stimulus against a frame-level scoreboard for two receiver instances:
// lane 0 at 16 clocks/bit, lane 1 at 4 clocks/bit for the fast 1024-wrap run.
`timescale 1ns/1ps
module tb_uart_byte_rx;

    localparam int  CPB   = 16;
    localparam int  CPB_S = 4;
    localparam real TCLK  = 10.0;

    logic clk   = 1'b0;
    logic nrst  = 1'b0;
    logic rxd_a = 1'b1;
    logic rxd_b = 1'b1;

    always #5 clk = ~clk;

    uart_byte_rx_if bus_a ();
    uart_byte_rx_if bus_b ();
    assign bus_a.rxd = rxd_a;
    assign bus_b.rxd = rxd_b;

    uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_a)
    );

    uart_byte_rx #(.CLKS_PER_BIT(CPB_S)) dut_short (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_b)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] expq0[$];
    logic [7:0] expq1[$];
    int         cntModel[2];
    int         writeExp[2];
    int         writeSeen[2];
    int         ferrExp[2];
    int         ferrSeen[2];
    logic [7:0] lastGood[2];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic resetModel();
        for (int l = 0; l < 2; l++) begin
            cntModel[l]  = 0;
            writeExp[l]  = 0;
            writeSeen[l] = 0;
            ferrExp[l]   = 0;
            ferrSeen[l]  = 0;
            lastGood[l]  = 8'd0;
        end
        expq0.delete();
        expq1.delete();
    endtask

    // Sends one frame on a lane with bit period bp (ns). When track is set, the expected
    // outcome is registered at the start of the stop bit, before the receiver can react.
    task automatic applyStimulus(input int lane, input logic [7:0] b, input logic stop,
                                 input real bp, input bit track);
        real        tStart;
        logic [9:0] frame;
        tStart = $realtime;
        frame  = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == 9 && track) begin
                if (stop) begin
                    writeExp[lane]++;
                    if (lane == 0) expq0.push_back(b);
                    else           expq1.push_back(b);
                end else begin
                    ferrExp[lane]++;
                end
            end
            if (lane == 0) rxd_a = frame[i];
            else           rxd_b = frame[i];
            #(tStart + (i + 1) * bp - $realtime);
        end
    endtask

    task automatic checkLane(input string tag, input int lane);
        logic [7:0] d;
        logic [9:0] bc;
        logic       bz;
        int         pend;
        if (lane == 0) begin
            d = bus_a.data; bc = bus_a.byte_cnt; bz = bus_a.busy; pend = expq0.size();
        end else begin
            d = bus_b.data; bc = bus_b.byte_cnt; bz = bus_b.busy; pend = expq1.size();
        end
        checkOutput({tag, "_writes"}, writeSeen[lane], writeExp[lane]);
        checkOutput({tag, "_ferrs"}, ferrSeen[lane], ferrExp[lane]);
        checkOutput({tag, "_pending"}, pend, 0);
        checkOutput({tag, "_data"}, d, lastGood[lane]);
        checkOutput({tag, "_byte_cnt"}, bc, cntModel[lane]);
        checkOutput({tag, "_busy"}, bz, 0);
    endtask

    // Scoreboard monitors: every write must match the next queued byte and the modular count.
    always @(negedge clk) begin
        if (nrst) begin
            if (bus_a.write) begin
                writeSeen[0]++;
                cntModel[0] = (cntModel[0] + 1) % 1024;
                if (expq0.size() == 0) begin
                    checkOutput("a_unexpected_write", 1, 0);
                end else begin
                    lastGood[0] = expq0.pop_front();
                    checkOutput("a_data", bus_a.data, lastGood[0]);
                end
                checkOutput("a_byte_cnt", bus_a.byte_cnt, cntModel[0]);
                checkOutput("a_busy_on_write", bus_a.busy, 0);
                checkOutput("a_write_with_ferr", bus_a.frame_err, 0);
            end
            if (bus_a.frame_err) ferrSeen[0]++;
        end
    end

    always @(negedge clk) begin
        if (nrst) begin
            if (bus_b.write) begin
                writeSeen[1]++;
                cntModel[1] = (cntModel[1] + 1) % 1024;
                if (expq1.size() == 0) begin
                    checkOutput("b_unexpected_write", 1, 0);
                end else begin
                    lastGood[1] = expq1.pop_front();
                    checkOutput("b_data", bus_b.data, lastGood[1]);
                end
                checkOutput("b_byte_cnt", bus_b.byte_cnt, cntModel[1]);
                checkOutput("b_busy_on_write", bus_b.busy, 0);
                checkOutput("b_write_with_ferr", bus_b.frame_err, 0);
            end
            if (bus_b.frame_err) ferrSeen[1]++;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        bit  found;
        real sweep[2];
        sweep[0] = 15.52 * TCLK;
        sweep[1] = 16.48 * TCLK;

        $display("[TB] reset");
        resetModel();
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data", bus_a.data, 0);
        checkOutput("rst_write", bus_a.write, 0);
        checkOutput("rst_ferr", bus_a.frame_err, 0);
        checkOutput("rst_busy", bus_a.busy, 0);
        checkOutput("rst_byte_cnt", bus_a.byte_cnt, 0);
        checkOutput("rst_b_busy", bus_b.busy, 0);
        checkOutput("rst_b_byte_cnt", bus_b.byte_cnt, 0);
        nrst = 1'b1;
        repeat (5) @(posedge clk);

        $display("[TB] single frame 0xA5 with latency");
        @(posedge clk);
        #2;
        fork
            applyStimulus(0, 8'hA5, 1'b1, CPB * TCLK, 1'b1);
            begin
                n = 0;
                found = 1'b0;
                while (!found && n < 400) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                    if (bus_a.write) found = 1'b1;
                end
            end
        join
        checkOutput("a5_latency", n, 2 + CPB / 2 + 9 * CPB + 1);
        repeat (20) @(posedge clk);
        checkLane("a5", 0);

        $display("[TB] start glitch");
        @(posedge clk);
        #2 rxd_a = 1'b0;
        repeat (4) @(posedge clk);
        #2 rxd_a = 1'b1;
        repeat (30) @(posedge clk);
        checkLane("glitch", 0);

        $display("[TB] framing error then held-low line");
        @(posedge clk);
        #2;
        applyStimulus(0, 8'h3C, 1'b0, CPB * TCLK, 1'b1);
        #(40 * TCLK);
        checkOutput("ferr_wait_busy", bus_a.busy, 1);
        checkOutput("ferr_count", ferrSeen[0], ferrExp[0]);
        checkOutput("ferr_data_held", bus_a.data, 8'hA5);
        checkOutput("ferr_no_write", writeSeen[0], writeExp[0]);
        rxd_a = 1'b1;
        repeat (10) @(posedge clk);
        checkLane("ferr_recover", 0);
        #2;
        applyStimulus(0, 8'h81, 1'b1, CPB * TCLK, 1'b1);
        repeat (20) @(posedge clk);
        checkLane("after_ferr", 0);

        $display("[TB] reset during bit 4");
        @(posedge clk);
        #2;
        fork
            applyStimulus(0, 8'hF3, 1'b1, CPB * TCLK, 1'b0);
            begin
                repeat (90) @(posedge clk);
                #1 nrst = 1'b0;
                #1;
                checkOutput("midrst_data", bus_a.data, 0);
                checkOutput("midrst_busy", bus_a.busy, 0);
                checkOutput("midrst_byte_cnt", bus_a.byte_cnt, 0);
                resetModel();
                @(posedge clk);
                #1 nrst = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        checkLane("midrst_abort", 0);
        #2;
        applyStimulus(0, 8'hFF, 1'b1, CPB * TCLK, 1'b1);
        repeat (20) @(posedge clk);
        checkLane("midrst_ff", 0);
        checkOutput("midrst_ff_cnt", bus_a.byte_cnt, 1);

        for (int s = 0; s < 2; s++) begin
            $display("[TB] rate sweep %0d ns/bit", int'(sweep[s]));
            @(posedge clk);
            #2;
            for (int f = 0; f < 32; f++)
                applyStimulus(0, 8'($urandom), 1'b1, sweep[s], 1'b1);
            repeat (30) @(posedge clk);
            checkLane("sweep", 0);
        end

        $display("[TB] 1025 back-to-back frames on short-period lane");
        @(posedge clk);
        #2;
        for (int f = 0; f < 1025; f++)
            applyStimulus(1, 8'($urandom_range(0, 255)), 1'b1, CPB_S * TCLK, 1'b1);
        repeat (20) @(posedge clk);
        checkLane("wrap", 1);
        checkOutput("wrap_writes", writeSeen[1], 1025);
        checkOutput("wrap_final_cnt", bus_b.byte_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
